// File: rtl/median3x3_filter.sv
// median3x3_filter: streaming 3x3 per-channel median filter for raster video.
// Two line buffers feed a 3x3 window; a pipelined sorting network produces
// the exact median of 9 for every interior pixel of a start/done framed image.
// Optional macro MEDIAN_PIPE_REG_EN adds a register mid-network (latency 3
// instead of 2 cycles from the accepting input cycle).
module median3x3_filter #(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720,
    parameter int CHANNELS     = 3,
    parameter int CHAN_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_i,
    input  logic                         pixel_valid_i,
    input  logic [CHANNELS*CHAN_W-1:0]   pixel_i,
    output logic                         pixel_valid_o,
    output logic [CHANNELS*CHAN_W-1:0]   pixel_o,
    output logic                         done_o,
    output logic                         busy_o
);

    localparam int PIX_W = CHANNELS * CHAN_W;
    localparam int XW    = $clog2(IMAGE_LEN);
    localparam int YW    = $clog2(IMAGE_HEIGHT);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state, state_next;
    logic              done_next;
    logic [XW-1:0]     x, x_next;
    logic [YW-1:0]     y, y_next;
    logic              accept;
    logic              last_pix;
    logic              pipe_empty;

    logic [PIX_W-1:0]  lb1 [IMAGE_LEN];   // row y-1
    logic [PIX_W-1:0]  lb2 [IMAGE_LEN];   // row y-2
    logic [PIX_W-1:0]  rd1, rd2;

    logic [PIX_W-1:0]  win_p0 [3][3];     // [row][col], row 2 / col 2 newest
    logic              vld_p0;

    logic [PIX_W-1:0]  row_lo [3], row_md [3], row_hi [3];
    logic [PIX_W-1:0]  b_lo [3], b_md [3], b_hi [3];
    logic [PIX_W-1:0]  red_mx, red_md, red_mn;
    logic [PIX_W-1:0]  c_mx, c_md, c_mn;
    logic [PIX_W-1:0]  med_out;
    logic              vld_c;
    logic              vld_p1;

    function automatic logic [CHAN_W-1:0] min2(input logic [CHAN_W-1:0] a, input logic [CHAN_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [CHAN_W-1:0] max2(input logic [CHAN_W-1:0] a, input logic [CHAN_W-1:0] b);
        return (a < b) ? b : a;
    endfunction

    function automatic logic [CHAN_W-1:0] min3(input logic [CHAN_W-1:0] a, input logic [CHAN_W-1:0] b,
                                                input logic [CHAN_W-1:0] c);
        return min2(min2(a, b), c);
    endfunction

    function automatic logic [CHAN_W-1:0] max3(input logic [CHAN_W-1:0] a, input logic [CHAN_W-1:0] b,
                                                input logic [CHAN_W-1:0] c);
        return max2(max2(a, b), c);
    endfunction

    function automatic logic [CHAN_W-1:0] med3(input logic [CHAN_W-1:0] a, input logic [CHAN_W-1:0] b,
                                                input logic [CHAN_W-1:0] c);
        return max2(min2(a, b), min2(max2(a, b), c));
    endfunction

    assign accept   = (state == RUN) && pixel_valid_i;
    assign last_pix = (x == XW'(IMAGE_LEN - 1)) && (y == YW'(IMAGE_HEIGHT - 1));

    // Raster position of the next pixel to be accepted.
    always_comb begin
        x_next = x;
        y_next = y;
        if (state == IDLE) begin
            x_next = '0;
            y_next = '0;
        end else if (accept) begin
            if (x == XW'(IMAGE_LEN - 1)) begin
                x_next = '0;
                y_next = y + 1'b1;
            end else begin
                x_next = x + 1'b1;
            end
        end
    end

    // Frame control: next state and done pulse.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE:    if (start_i) state_next = RUN;
            RUN:     if (accept && last_pix) state_next = DRAIN;
            DRAIN: begin
                if (pipe_empty) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control registers: state, raster counters, done/busy flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            x      <= '0;
            y      <= '0;
            done_o <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            state  <= state_next;
            x      <= x_next;
            y      <= y_next;
            done_o <= done_next;
            busy_o <= (state_next != IDLE);
        end
    end

    // Line buffers; the read address runs one pixel ahead so the registered
    // read data for column x is ready (pre-write) whenever that pixel arrives.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[x] <= pixel_i;
            lb2[x] <= rd1;
        end
        rd1 <= lb1[x_next];
        rd2 <= lb2[x_next];
    end

    // ---- stage p0: 3x3 window, advanced only on accepted pixels ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_p0[r][c] <= '0;
        end else begin
            vld_p0 <= accept && (x >= XW'(2)) && (y >= YW'(2));
            if (accept) begin
                for (int r = 0; r < 3; r++) begin
                    win_p0[r][0] <= win_p0[r][1];
                    win_p0[r][1] <= win_p0[r][2];
                end
                win_p0[0][2] <= rd2;
                win_p0[1][2] <= rd1;
                win_p0[2][2] <= pixel_i;
            end
        end
    end

    // Sort each window row into low/mid/high per channel.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            row_lo[r] = '0;
            row_md[r] = '0;
            row_hi[r] = '0;
            for (int c = 0; c < CHANNELS; c++) begin
                row_lo[r][c*CHAN_W +: CHAN_W] = min3(win_p0[r][0][c*CHAN_W +: CHAN_W],
                    win_p0[r][1][c*CHAN_W +: CHAN_W], win_p0[r][2][c*CHAN_W +: CHAN_W]);
                row_md[r][c*CHAN_W +: CHAN_W] = med3(win_p0[r][0][c*CHAN_W +: CHAN_W],
                    win_p0[r][1][c*CHAN_W +: CHAN_W], win_p0[r][2][c*CHAN_W +: CHAN_W]);
                row_hi[r][c*CHAN_W +: CHAN_W] = max3(win_p0[r][0][c*CHAN_W +: CHAN_W],
                    win_p0[r][1][c*CHAN_W +: CHAN_W], win_p0[r][2][c*CHAN_W +: CHAN_W]);
            end
        end
    end

    // Column reduction: max of lows, median of mids, min of highs.
    always_comb begin
        red_mx = '0;
        red_md = '0;
        red_mn = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            red_mx[c*CHAN_W +: CHAN_W] = max3(b_lo[0][c*CHAN_W +: CHAN_W],
                b_lo[1][c*CHAN_W +: CHAN_W], b_lo[2][c*CHAN_W +: CHAN_W]);
            red_md[c*CHAN_W +: CHAN_W] = med3(b_md[0][c*CHAN_W +: CHAN_W],
                b_md[1][c*CHAN_W +: CHAN_W], b_md[2][c*CHAN_W +: CHAN_W]);
            red_mn[c*CHAN_W +: CHAN_W] = min3(b_hi[0][c*CHAN_W +: CHAN_W],
                b_hi[1][c*CHAN_W +: CHAN_W], b_hi[2][c*CHAN_W +: CHAN_W]);
        end
    end

`ifdef MEDIAN_PIPE_REG_EN
    logic [PIX_W-1:0] row_lo_p1 [3], row_md_p1 [3], row_hi_p1 [3];
    logic [PIX_W-1:0] red_mx_p2, red_md_p2, red_mn_p2;
    logic             vld_p2;

    // ---- stage p1: sorted rows (extra mid-network register) ----
    always_ff @(posedge clk) begin
        row_lo_p1 <= row_lo;
        row_md_p1 <= row_md;
        row_hi_p1 <= row_hi;
    end

    // Stage valids p1/p2.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
        end
    end

    // Column reduction fed from the registered rows.
    always_comb begin
        b_lo = row_lo_p1;
        b_md = row_md_p1;
        b_hi = row_hi_p1;
    end

    // ---- stage p2: reduced triple ----
    always_ff @(posedge clk) begin
        red_mx_p2 <= red_mx;
        red_md_p2 <= red_md;
        red_mn_p2 <= red_mn;
    end

    // Final median sources from stage p2.
    always_comb begin
        c_mx       = red_mx_p2;
        c_md       = red_md_p2;
        c_mn       = red_mn_p2;
        vld_c      = vld_p2;
        pipe_empty = !vld_p0 && !vld_p1 && !vld_p2;
    end
`else
    logic [PIX_W-1:0] red_mx_p1, red_md_p1, red_mn_p1;

    // Column reduction fed directly from the window row sort.
    always_comb begin
        b_lo = row_lo;
        b_md = row_md;
        b_hi = row_hi;
    end

    // ---- stage p1: reduced triple ----
    always_ff @(posedge clk) begin
        red_mx_p1 <= red_mx;
        red_md_p1 <= red_md;
        red_mn_p1 <= red_mn;
    end

    // Stage valid p1.
    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= vld_p0;
    end

    // Final median sources from stage p1.
    always_comb begin
        c_mx       = red_mx_p1;
        c_md       = red_md_p1;
        c_mn       = red_mn_p1;
        vld_c      = vld_p1;
        pipe_empty = !vld_p0 && !vld_p1;
    end
`endif

    // Median of the reduced triple is the median of all nine samples.
    always_comb begin
        med_out = '0;
        for (int c = 0; c < CHANNELS; c++)
            med_out[c*CHAN_W +: CHAN_W] = med3(c_mx[c*CHAN_W +: CHAN_W],
                c_md[c*CHAN_W +: CHAN_W], c_mn[c*CHAN_W +: CHAN_W]);
    end

    // ---- output stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_valid_o <= 1'b0;
            pixel_o       <= '0;
        end else begin
            pixel_valid_o <= vld_c;
            if (vld_c) pixel_o <= med_out;
        end
    end

endmodule

// File: tb/tb_median3x3_filter.sv
// Testbench for median3x3_filter on a 4x3 RGB frame with a scoreboard of
// model-computed medians and their required output cycles.
module tb_median3x3_filter;

    localparam int LEN = 4;
    localparam int H   = 3;
    localparam int CH  = 3;
    localparam int W   = 8;
    localparam int PW  = CH * W;
`ifdef MEDIAN_PIPE_REG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          pixel_valid_i;
    logic [PW-1:0] pixel_i;
    logic          pixel_valid_o;
    logic [PW-1:0] pixel_o;
    logic          done_o;
    logic          busy_o;

    median3x3_filter #(.IMAGE_LEN(LEN), .IMAGE_HEIGHT(H), .CHANNELS(CH), .CHAN_W(W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .pixel_valid_i(pixel_valid_i),
        .pixel_i(pixel_i), .pixel_valid_o(pixel_valid_o), .pixel_o(pixel_o),
        .done_o(done_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] val;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    logic [PW-1:0] img [0:H-1][0:LEN-1];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            n_out = 0;
    int            n_done = 0;
    int            last_out_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [PW-1:0] pix_of(input int mode, input int idx);
        logic [7:0] r, g, b;
        if (mode == 0) return 24'h101010;
        r = (idx == 5) ? 8'hFF : 8'(idx);
        g = (mode == 2) ? 8'(11 - idx) : 8'h00;
        b = (mode == 2) ? 8'h80 : 8'h00;
        return {b, g, r};
    endfunction

    function automatic logic [PW-1:0] model_median(input int cx, input int cy);
        logic [PW-1:0] res;
        logic [7:0]    v [9];
        logic [7:0]    t;
        int            k;
        res = '0;
        for (int ch = 0; ch < CH; ch++) begin
            k = 0;
            for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++) begin
                    v[k] = img[cy+dy][cx+dx][ch*W +: W];
                    k++;
                end
            for (int i = 0; i < 8; i++)
                for (int j = 0; j < 8 - i; j++)
                    if (v[j] > v[j+1]) begin
                        t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                    end
            res[ch*W +: W] = v[4];
        end
        return res;
    endfunction

    // Output monitor: pops the scoreboard on every output and checks timing of done.
    always @(negedge clk) begin
        exp_t e;
        if (pixel_valid_o === 1'b1) begin
            n_out++;
            last_out_cyc = cyc;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h at cycle %0d, none expected", pixel_o, cyc);
            end else begin
                e = sb.pop_front();
                if (pixel_o !== e.val) begin
                    errors++;
                    $display("FAIL output_value: got %h, expected %h", pixel_o, e.val);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    errors++;
                    $display("FAIL output_latency: at cycle %0d, expected cycle %0d", cyc, e.cyc);
                end
            end
        end
        if (done_o === 1'b1) begin
            n_done++;
            checks++;
            if (cyc !== last_out_cyc + 1 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL done_timing: done at cycle %0d busy=%b, expected cycle %0d busy=0",
                         cyc, busy_o, last_out_cyc + 1);
            end
        end
    end

    task automatic do_start(input bit with_pix);
        start_i       = 1'b1;
        pixel_valid_i = with_pix;
        pixel_i       = '1;
        @(negedge clk);
        start_i       = 1'b0;
        pixel_valid_i = 1'b0;
    endtask

    task automatic drive_frame(input int mode, input bit gaps, input int npix, input int start_at);
        exp_t e;
        for (int idx = 0; idx < npix; idx++) begin
            int px, py;
            px = idx % LEN;
            py = idx / LEN;
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    pixel_valid_i = 1'b0;
                    @(negedge clk);
                end
            end
            pixel_valid_i = 1'b1;
            pixel_i       = pix_of(mode, idx);
            start_i       = (idx == start_at);
            img[py][px]   = pixel_i;
            if (px >= 2 && py >= 2) begin
                e.val = model_median(px - 1, py - 1);
                e.cyc = cyc + 1 + LAT;
                sb.push_back(e);
            end
            @(negedge clk);
        end
        pixel_valid_i = 1'b0;
        start_i       = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start_i = 1'b0; pixel_valid_i = 1'b0; pixel_i = '0;
        repeat (3) @(negedge clk);
        checks++; if (pixel_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", pixel_valid_o); end
        checks++; if (pixel_o !== '0) begin errors++; $display("FAIL reset_pixel: got %h, expected 0", pixel_o); end
        checks++; if (done_o !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy_o); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_frame(input string name, input int mode, input bit gaps);
        bit seen;
        n_out = 0; n_done = 0;
        do_start(1'b0);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL %s_busy_start: got %b, expected 1", name, busy_o); end
        drive_frame(mode, gaps, LEN * H, -1);
        wait_done(seen);
        checks++; if (!seen) begin errors++; $display("FAIL %s_done_timeout: done_o not seen, expected pulse", name); end
        checks++; if (n_out !== (LEN - 2) * (H - 2)) begin errors++; $display("FAIL %s_count: got %0d outputs, expected %0d", name, n_out, (LEN-2)*(H-2)); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL %s_pending: %0d expected outputs missing, expected 0", name, sb.size()); end
        @(negedge clk);
        checks++; if (done_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL %s_done_pulse: done=%b busy=%b, expected 0 0", name, done_o, busy_o); end
        checks++; if (n_done !== 1) begin errors++; $display("FAIL %s_done_count: got %0d, expected 1", name, n_done); end
        sb.delete();
    endtask

    task automatic test_reset_mid(input int n);
        n_out = 0; n_done = 0;
        do_start(1'b0);
        drive_frame(1, 1'b0, n, -1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (pixel_valid_o !== 1'b0 || done_o !== 1'b0 || busy_o !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_quiet: valid=%b done=%b busy=%b, expected 0 0 0", pixel_valid_o, done_o, busy_o);
            end
        end
        checks++; if (n_out !== 0 || n_done !== 0) begin errors++; $display("FAIL reset_mid_discard: outputs=%0d dones=%0d, expected 0 0", n_out, n_done); end
        test_frame("after_reset", 0, 1'b0);
    endtask

    task automatic test_ignored_inputs;
        bit seen;
        n_out = 0; n_done = 0;
        for (int i = 0; i < 5; i++) begin
            pixel_valid_i = 1'b1;
            pixel_i       = PW'($urandom);
            @(negedge clk);
        end
        pixel_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (busy_o !== 1'b0 || n_out !== 0) begin errors++; $display("FAIL idle_pixels: busy=%b outputs=%0d, expected 0 0", busy_o, n_out); end
        do_start(1'b1);
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL ignore_busy_start: got %b, expected 1", busy_o); end
        drive_frame(0, 1'b0, LEN * H, 4);
        wait_done(seen);
        checks++; if (!seen) begin errors++; $display("FAIL ignore_done_timeout: done_o not seen, expected pulse"); end
        checks++; if (n_out !== 2) begin errors++; $display("FAIL ignore_count: got %0d outputs, expected 2", n_out); end
        checks++; if (sb.size() !== 0) begin errors++; $display("FAIL ignore_pending: %0d missing, expected 0", sb.size()); end
        @(negedge clk);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_frame("constant", 0, 1'b0);
        test_frame("impulse", 1, 1'b0);
        test_frame("channels", 2, 1'b0);
        test_frame("valid_gaps", 1, 1'b1);
        test_frame("back_to_back", 2, 1'b1);
        test_reset_mid(7);
        test_reset_mid(11);
        test_ignored_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
